// File: rtl/pc_sequencer_if.sv
// Decoder-side bundle for the PC sequencer.
// The master modport is the decoder/comparator side: it drives the decode and
// exception inputs and reads the fetch address outputs. The slave modport is
// the sequencer itself.
//   stall          hold all sequencer state this cycle
//   is_branch      current instruction is a conditional branch
//   br_taken       branch condition true (qualified by is_branch)
//   is_j / is_jr   j/jal and jr/jalr decoded
//   imm16          branch word offset, instr[15:0]
//   instr_index    jump field, instr[25:0]
//   rs_value       register rs value for jr/jalr
//   exc_req        exception request
//   eret / epc     return from exception and its return address
//   pc             address of instruction currently fetched/executed
//   pc_plus4       pc + 4
//   link_addr      pc + 8
//   in_delay_slot  current instruction sits in a delay slot
//   slot_violation one-cycle pulse: transfer decoded inside a delay slot
interface pc_sequencer_if;
  logic        stall;
  logic        is_branch;
  logic        br_taken;
  logic        is_j;
  logic        is_jr;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_value;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] link_addr;
  logic        in_delay_slot;
  logic        slot_violation;

  modport master (
    output stall, is_branch, br_taken, is_j, is_jr, imm16, instr_index,
           rs_value, exc_req, eret, epc,
    input  pc, pc_plus4, link_addr, in_delay_slot, slot_violation
  );

  modport slave (
    input  stall, is_branch, br_taken, is_j, is_jr, imm16, instr_index,
           rs_value, exc_req, eret, epc,
    output pc, pc_plus4, link_addr, in_delay_slot, slot_violation
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer for the single-issue MIPS core.
// Owns the PC and sequences sequential fetch, conditional branches, j/jal,
// jr/jalr, exception entry and eret, including the one-instruction branch
// delay slot.
//   clk  core clock, rising edge
//   rst  synchronous active-high reset
//   bus  decoder-side bundle (slave modport), see pc_sequencer_if
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  localparam logic [0:0] S_SEQ  = 1'b0;
  localparam logic [0:0] S_SLOT = 1'b1;

  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [0:0]  state_q, state_d;
  logic        slot_violation_q, slot_violation_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] sel_target;
  logic        xfer;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign j_target  = {pc_plus4[31:28], bus.instr_index, 2'b00};
  assign xfer      = bus.is_jr | bus.is_j | (bus.is_branch & bus.br_taken);

  // jr > j > branch when several transfer kinds are flagged together
  always_comb begin
    if (bus.is_jr)     sel_target = bus.rs_value;
    else if (bus.is_j) sel_target = j_target;
    else               sel_target = br_target;
  end

  always_comb begin
    pc_d             = pc_q;
    target_d         = target_q;
    state_d          = state_q;
    slot_violation_d = 1'b0;
    if (bus.exc_req) begin
      // exception entry overrides stall and drops any pending target
      pc_d     = EXC_VECTOR;
      target_d = '0;
      state_d  = S_SEQ;
    end else if (bus.stall) begin
      // hold everything; violation pulse still clears
    end else if (bus.eret) begin
      pc_d     = bus.epc;
      target_d = '0;
      state_d  = S_SEQ;
    end else if (state_q == S_SEQ) begin
      pc_d = pc_plus4;
      if (xfer) begin
        target_d = sel_target;
        state_d  = S_SLOT;
      end
    end else begin
      // delay slot retires: take the saved target, flag any nested transfer
      pc_d             = target_q;
      state_d          = S_SEQ;
      slot_violation_d = xfer;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      target_q         <= '0;
      state_q          <= S_SEQ;
      slot_violation_q <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      target_q         <= target_d;
      state_q          <= state_d;
      slot_violation_q <= slot_violation_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_plus4       = pc_plus4;
  assign bus.link_addr      = pc_q + 32'd8;
  assign bus.in_delay_slot  = (state_q == S_SLOT);
  assign bus.slot_violation = slot_violation_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_PC = 32'h0040_0004;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: the upcoming fetch addresses are a plan queue. A taken
  // transfer outside a slot schedules {pc+4, target}; while the plan is not
  // empty the current instruction is a delay slot.
  logic [31:0] m_pc;
  logic [31:0] plan[$];
  logic        m_viol;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  task automatic clear_inputs();
    rst             = 1'b0;
    bus.stall       = 1'b0;
    bus.is_branch   = 1'b0;
    bus.br_taken    = 1'b0;
    bus.is_j        = 1'b0;
    bus.is_jr       = 1'b0;
    bus.imm16       = '0;
    bus.instr_index = '0;
    bus.rs_value    = '0;
    bus.exc_req     = 1'b0;
    bus.eret        = 1'b0;
    bus.epc         = '0;
  endtask

  function automatic logic [31:0] model_target(input logic [31:0] cur);
    int off;
    if (bus.is_jr) return bus.rs_value;
    if (bus.is_j)  return {cur[31:28] + ((cur[31:2] == 30'h3FFF_FFFF) ? 4'h1 : 4'h0),
                           bus.instr_index, 2'b00};
    off = int'($signed(bus.imm16)) * 4;
    return cur + 32'd4 + 32'(off);
  endfunction

  task automatic model_edge();
    logic xfer;
    xfer = bus.is_jr | bus.is_j | (bus.is_branch & bus.br_taken);
    if (rst) begin
      m_pc = RST_PC; plan.delete(); m_viol = 1'b0;
    end else if (bus.exc_req) begin
      m_pc = EXC_PC; plan.delete(); m_viol = 1'b0;
    end else if (bus.stall) begin
      m_viol = 1'b0;
    end else if (bus.eret) begin
      m_pc = bus.epc; plan.delete(); m_viol = 1'b0;
    end else begin
      m_viol = xfer && (plan.size() != 0);
      if (xfer && plan.size() == 0) begin
        plan.push_back(m_pc + 32'd4);
        plan.push_back(model_target(m_pc));
      end
      if (plan.size() != 0) m_pc = plan.pop_front();
      else                  m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock: model follows the inputs currently driven, DUT sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pc",             bus.pc,                   m_pc);
    check("pc_plus4",       bus.pc_plus4,             m_pc + 32'd4);
    check("link_addr",      bus.link_addr,            m_pc + 32'd8);
    check("in_delay_slot",  {31'd0, bus.in_delay_slot},  {31'd0, plan.size() != 0});
    check("slot_violation", {31'd0, bus.slot_violation}, {31'd0, m_viol});
    clear_inputs();
  endtask

  initial begin
    m_pc = RST_PC; m_viol = 1'b0;
    clear_inputs();

    // reset then sequential
    rst = 1'b1; step();
    check("rst_pc", bus.pc, 32'h0040_0000);
    check("rst_slot", {31'd0, bus.in_delay_slot}, 32'd0);
    step(); check("seq1", bus.pc, 32'h0040_0004);
    step(); check("seq2", bus.pc, 32'h0040_0008);
    step(); check("seq3", bus.pc, 32'h0040_000C);
    check("seq3_link", bus.link_addr, 32'h0040_0014);
    step();

    // taken branch, negative offset
    bus.is_branch = 1'b1; bus.br_taken = 1'b1; bus.imm16 = 16'hFFFC; step();
    check("br_slot_pc", bus.pc, 32'h0040_0014);
    check("br_slot_flag", {31'd0, bus.in_delay_slot}, 32'd1);
    step(); check("br_target", bus.pc, 32'h0040_0004);
    step(); step(); step();

    // not-taken branch
    bus.is_branch = 1'b1; bus.br_taken = 1'b0; bus.imm16 = 16'hFFFC; step();
    check("nt_pc", bus.pc, 32'h0040_0014);
    check("nt_slot", {31'd0, bus.in_delay_slot}, 32'd0);
    step(); check("nt_next", bus.pc, 32'h0040_0018);
    step(); step();

    // jump, then jr beating j
    bus.is_j = 1'b1; bus.instr_index = 26'h010_0040; step();
    check("j_slot", bus.pc, 32'h0040_0024);
    step(); check("j_target", bus.pc, 32'h0040_0100);
    bus.is_jr = 1'b1; bus.is_j = 1'b1; bus.instr_index = 26'h000_0001;
    bus.rs_value = 32'h0040_1000; step();
    step(); check("jr_prio", bus.pc, 32'h0040_1000);

    // stall inside the slot
    bus.is_branch = 1'b1; bus.br_taken = 1'b1; bus.imm16 = 16'hFC1F; step();
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1; step();
      check("stall_pc", bus.pc, 32'h0040_1004);
      check("stall_slot", {31'd0, bus.in_delay_slot}, 32'd1);
    end
    step(); check("stall_release", bus.pc, 32'h0040_0080);

    // exception in slot with stall, later eret
    bus.is_j = 1'b1; bus.instr_index = 26'h010_0080; step();
    bus.exc_req = 1'b1; bus.stall = 1'b1; step();
    check("exc_pc", bus.pc, 32'h0040_0004);
    check("exc_slot", {31'd0, bus.in_delay_slot}, 32'd0);
    step(); check("exc_discard", bus.pc, 32'h0040_0008);
    bus.eret = 1'b1; bus.epc = 32'h0040_0200; step();
    check("eret_pc", bus.pc, 32'h0040_0200);

    // reset in the middle of a slot
    bus.is_j = 1'b1; bus.instr_index = 26'h010_0040; step();
    rst = 1'b1; step();
    check("rst_mid_pc", bus.pc, 32'h0040_0000);
    check("rst_mid_slot", {31'd0, bus.in_delay_slot}, 32'd0);

    // slot violation
    bus.is_j = 1'b1; bus.instr_index = 26'h010_0040; step();
    bus.is_j = 1'b1; bus.instr_index = 26'h000_0010; step();
    check("viol_pulse", {31'd0, bus.slot_violation}, 32'd1);
    check("viol_target", bus.pc, 32'h0040_0100);
    step(); check("viol_clear", {31'd0, bus.slot_violation}, 32'd0);

    // wrap-around
    bus.is_jr = 1'b1; bus.rs_value = 32'hFFFF_FFFC; step();
    step(); check("wrap_at", bus.pc, 32'hFFFF_FFFC);
    check("wrap_plus4", bus.pc_plus4, 32'h0000_0000);
    bus.is_branch = 1'b1; bus.br_taken = 1'b1; bus.imm16 = 16'h0001; step();
    check("wrap_slot", bus.pc, 32'h0000_0000);
    step(); check("wrap_target", bus.pc, 32'h0000_0004);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 99) == 0);
      bus.exc_req     = ($urandom_range(0, 39) == 0);
      bus.eret        = ($urandom_range(0, 29) == 0);
      bus.stall       = ($urandom_range(0, 4) == 0);
      bus.is_branch   = ($urandom_range(0, 3) == 0);
      bus.br_taken    = $urandom_range(0, 1) == 1;
      bus.is_j        = ($urandom_range(0, 7) == 0);
      bus.is_jr       = ($urandom_range(0, 9) == 0);
      bus.imm16       = 16'($urandom);
      bus.instr_index = 26'($urandom);
      bus.rs_value    = $urandom;
      bus.epc         = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
